// File: rtl/uart_tx_serializer_cfg.sv
// Parallel-to-serial engine for the UART TX path: one-entry holding buffer, runtime
// frame length and bit order. Define SER_PARITY_EN to add the frame parity register.
module uart_tx_serializer_cfg #(
    parameter int DATA_WIDTH = 9,
    parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  p_valid,
    output logic                  p_ready,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic                  cfg_msb_first,
    input  logic                  cfg_par_odd,
    input  logic                  ser_start,
    input  logic                  ser_en,
    output logic                  ser_data,
    output logic                  ser_done,
    output logic                  ser_busy,
    output logic                  buf_full,
    output logic                  par_bit
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  msb_q, msb_d;
    logic                  buf_full_q, buf_full_d;
    logic [LEN_W-1:0]      len_clamped;
    logic                  load;
    logic                  last_bit;

    // Out-of-range lengths are folded into 1..DATA_WIDTH before being latched.
    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == '0)
            len_clamped = LEN_W'(1);
        else if (cfg_len > LEN_W'(DATA_WIDTH))
            len_clamped = LEN_W'(DATA_WIDTH);
    end

    assign load     = (state_q == IDLE) && ser_start && buf_full_q;
    assign last_bit = (state_q == SHIFT) && (cnt_q == len_q - LEN_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = SHIFT;
            SHIFT:   if (ser_en && last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ser_busy = (state_q == SHIFT);
        ser_done = last_bit;
        ser_data = 1'b1;
        if (state_q == SHIFT)
            ser_data = msb_q ? shreg_q[len_q - LEN_W'(1)] : shreg_q[0];
    end

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        hold_d     = hold_q;
        buf_full_d = buf_full_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        msb_d      = msb_q;
        // Acceptance depends only on the registered full flag; load and accept are exclusive.
        if (p_valid && !buf_full_q) begin
            hold_d     = p_data;
            buf_full_d = 1'b1;
        end
        if (load) begin
            shreg_d    = hold_q;
            cnt_d      = '0;
            buf_full_d = 1'b0;
            len_d      = len_clamped;
            msb_d      = cfg_msb_first;
        end else if ((state_q == SHIFT) && ser_en) begin
            cnt_d   = cnt_q + LEN_W'(1);
            shreg_d = msb_q ? (shreg_q << 1) : (shreg_q >> 1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    // The holding register is reset too, so an aborted frame leaves nothing to replay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q     <= '0;
            buf_full_q <= 1'b0;
            shreg_q    <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            msb_q      <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            buf_full_q <= buf_full_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            msb_q      <= msb_d;
        end
    end

    assign p_ready  = !buf_full_q;
    assign buf_full = buf_full_q;

`ifdef SER_PARITY_EN
    logic                  par_q, par_d;
    logic [DATA_WIDTH-1:0] len_mask;

    // Parity covers only the bits that will actually be shifted out.
    always_comb begin
        for (int i = 0; i < DATA_WIDTH; i++)
            len_mask[i] = (i < int'(len_clamped));
        par_d = par_q;
        if (load)
            par_d = (^(hold_q & len_mask)) ^ cfg_par_odd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            par_q <= 1'b0;
        else
            par_q <= par_d;
    end

    assign par_bit = par_q;
`else
    logic unused_par_odd;

    assign unused_par_odd = cfg_par_odd;
    assign par_bit        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_serializer_cfg.sv
// Self-checking bench for uart_tx_serializer_cfg: directed frames plus randomized frames
// compared against a bit-list model of the frame; parity expectations follow SER_PARITY_EN.
module tb_uart_tx_serializer_cfg;

    localparam int DW = 9;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] p_data;
    logic          p_valid;
    logic          p_ready;
    logic [LW-1:0] cfg_len;
    logic          cfg_msb_first;
    logic          cfg_par_odd;
    logic          ser_start;
    logic          ser_en;
    logic          ser_data;
    logic          ser_done;
    logic          ser_busy;
    logic          buf_full;
    logic          par_bit;

    int checks   = 0;
    int failures = 0;

    uart_tx_serializer_cfg #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .p_data        (p_data),
        .p_valid       (p_valid),
        .p_ready       (p_ready),
        .cfg_len       (cfg_len),
        .cfg_msb_first (cfg_msb_first),
        .cfg_par_odd   (cfg_par_odd),
        .ser_start     (ser_start),
        .ser_en        (ser_en),
        .ser_data      (ser_data),
        .ser_done      (ser_done),
        .ser_busy      (ser_busy),
        .buf_full      (buf_full),
        .par_bit       (par_bit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the frame is the list of the low L bits in the chosen order.
    function automatic int clamp_len(input int l);
        if (l == 0) return 1;
        if (l > DW) return DW;
        return l;
    endfunction

    function automatic logic exp_bit(input logic [DW-1:0] w, input int l, input logic msb,
                                     input int i);
        return msb ? w[l - 1 - i] : w[i];
    endfunction

    function automatic logic exp_par(input logic [DW-1:0] w, input int l, input logic odd);
`ifdef SER_PARITY_EN
        int ones = 0;
        for (int k = 0; k < l; k++) ones += int'(w[k]);
        return logic'(ones % 2) ^ odd;
`else
        return 1'b0;
`endif
    endfunction

    task automatic load_word(input logic [DW-1:0] w);
        int n = 0;
        while (!p_ready && n < 50) begin
            step();
            n++;
        end
        chk("load_ready", p_ready, 1'b1);
        p_data  = w;
        p_valid = 1'b1;
        step();
        p_valid = 1'b0;
        chk("load_full", buf_full, 1'b1);
        chk("load_p_ready", p_ready, 1'b0);
    endtask

    task automatic start_frame(input logic [DW-1:0] w, input int l, input logic msb,
                               input logic odd);
        cfg_len       = LW'(l);
        cfg_msb_first = msb;
        cfg_par_odd   = odd;
        ser_start     = 1'b1;
        step();
        ser_start = 1'b0;
        chk("start_busy", ser_busy, 1'b1);
        chk("start_buf_empty", buf_full, 1'b0);
        chk("par_bit", par_bit, exp_par(w, clamp_len(l), odd));
    endtask

    task automatic shift_frame(input logic [DW-1:0] w, input int l, input logic msb,
                               input logic refill, input logic [DW-1:0] refill_w,
                               input logic stalls);
        int L = clamp_len(l);
        ser_en = 1'b1;
        for (int i = 0; i < L; i++) begin
            chk("shift_busy", ser_busy, 1'b1);
            chk("shift_data", ser_data, exp_bit(w, L, msb, i));
            chk("shift_done", ser_done, logic'(i == L - 1));
            if (refill && i == 1) chk("refill_p_ready", p_ready, 1'b0);
            if (stalls && $urandom_range(0, 2) == 0) begin
                ser_en  = 1'b0;
                p_valid = 1'b0;
                step();
                chk("stall_data", ser_data, exp_bit(w, L, msb, i));
                chk("stall_done", ser_done, logic'(i == L - 1));
                ser_en = 1'b1;
            end
            p_valid       = refill && (i == 0);
            p_data        = refill_w;
            cfg_len       = LW'($urandom_range(0, 15));
            cfg_msb_first = 1'($urandom_range(0, 1));
            cfg_par_odd   = 1'($urandom_range(0, 1));
            ser_start     = 1'($urandom_range(0, 1));
            step();
        end
        ser_en    = 1'b0;
        p_valid   = 1'b0;
        ser_start = 1'b0;
        chk("end_busy", ser_busy, 1'b0);
        chk("end_mark", ser_data, 1'b1);
        chk("end_done", ser_done, 1'b0);
        chk("end_buf_full", buf_full, refill);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w;
        logic [DW-1:0] pw;
        logic          have;
        logic          refill;
        logic [DW-1:0] rw;
        int            l;
        logic          msb;
        logic          odd;

        rst = 1'b0; p_data = '0; p_valid = 1'b0; cfg_len = '0; cfg_msb_first = 1'b0;
        cfg_par_odd = 1'b0; ser_start = 1'b0; ser_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_p_ready", p_ready, 1'b1);
        chk("rst_ser_data", ser_data, 1'b1);
        chk("rst_ser_done", ser_done, 1'b0);
        chk("rst_ser_busy", ser_busy, 1'b0);
        chk("rst_buf_full", buf_full, 1'b0);
        chk("rst_par_bit", par_bit, 1'b0);
        rst = 1'b1;
        step();

        // Start with an empty buffer is ignored.
        ser_start = 1'b1;
        step();
        ser_start = 1'b0;
        chk("empty_start_busy", ser_busy, 1'b0);
        chk("empty_start_mark", ser_data, 1'b1);

        // 0xA5, 8 bits, LSB then MSB first, both parity senses.
        load_word(9'h0A5);
        start_frame(9'h0A5, 8, 1'b0, 1'b0);
        shift_frame(9'h0A5, 8, 1'b0, 1'b0, '0, 1'b0);
        load_word(9'h0A5);
        start_frame(9'h0A5, 8, 1'b1, 1'b1);
        shift_frame(9'h0A5, 8, 1'b1, 1'b0, '0, 1'b0);
        load_word(9'h013);
        start_frame(9'h013, 5, 1'b1, 1'b0);
        shift_frame(9'h013, 5, 1'b1, 1'b0, '0, 1'b0);

        // Back-to-back: 0x3C accepted mid-frame, started right after the last bit.
        load_word(9'h0A5);
        start_frame(9'h0A5, 8, 1'b0, 1'b0);
        shift_frame(9'h0A5, 8, 1'b0, 1'b1, 9'h03C, 1'b0);
        start_frame(9'h03C, 8, 1'b0, 1'b1);
        shift_frame(9'h03C, 8, 1'b0, 1'b0, '0, 1'b0);

        // p_valid while full must not overwrite the buffered word.
        load_word(9'h0F0);
        p_data  = 9'h1FF;
        p_valid = 1'b1;
        step();
        p_valid = 1'b0;
        chk("full_ignore_full", buf_full, 1'b1);
        start_frame(9'h0F0, 9, 1'b0, 1'b0);
        shift_frame(9'h0F0, 9, 1'b0, 1'b0, '0, 1'b0);

        // Length boundaries: 0 becomes 1, 15 becomes 9.
        load_word(9'h001);
        start_frame(9'h001, 0, 1'b0, 1'b0);
        shift_frame(9'h001, 0, 1'b0, 1'b0, '0, 1'b0);
        load_word(9'h1A5);
        start_frame(9'h1A5, 15, 1'b1, 1'b0);
        shift_frame(9'h1A5, 15, 1'b1, 1'b0, '0, 1'b0);

        // Randomized frames with refills, stalls and config churn during SHIFT.
        have = 1'b0;
        pw   = '0;
        for (int f = 0; f < 30; f++) begin
            if (have) begin
                w = pw;
            end else begin
                w = DW'($urandom);
                load_word(w);
            end
            l      = int'($urandom_range(0, 15));
            msb    = 1'($urandom_range(0, 1));
            odd    = 1'($urandom_range(0, 1));
            refill = 1'($urandom_range(0, 1));
            rw     = DW'($urandom);
            start_frame(w, l, msb, odd);
            shift_frame(w, l, msb, refill, rw, 1'b1);
            have = refill;
            pw   = rw;
        end
        if (have) begin
            start_frame(pw, 8, 1'b0, 1'b0);
            shift_frame(pw, 8, 1'b0, 1'b0, '0, 1'b0);
        end

        // Asynchronous reset on bit 4 with the buffer full.
        load_word(9'h0A5);
        start_frame(9'h0A5, 8, 1'b0, 1'b0);
        ser_en  = 1'b1;
        p_data  = 9'h03C;
        p_valid = 1'b1;
        step();
        p_valid = 1'b0;
        step();
        step();
        chk("pre_rst_full", buf_full, 1'b1);
        chk("pre_rst_bit4", ser_data, exp_bit(9'h0A5, 8, 1'b0, 3));
        #2;
        rst = 1'b0;
        #1;
        chk("arst_p_ready", p_ready, 1'b1);
        chk("arst_ser_data", ser_data, 1'b1);
        chk("arst_ser_done", ser_done, 1'b0);
        chk("arst_ser_busy", ser_busy, 1'b0);
        chk("arst_buf_full", buf_full, 1'b0);
        chk("arst_par_bit", par_bit, 1'b0);
        ser_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("post_rst_busy", ser_busy, 1'b0);
        chk("post_rst_full", buf_full, 1'b0);
        ser_start = 1'b1;
        step();
        ser_start = 1'b0;
        chk("post_rst_start_busy", ser_busy, 1'b0);
        chk("post_rst_mark", ser_data, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
